// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// Pure declarations; no logic, no latency, no flow control.
package loader_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_RUN  = 1'b1;

  localparam int PROG_DEPTH = 256;
  localparam int WORD_W     = 16;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] operand;
  } word_t;

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver: 2-FF synchroniser, start-bit glitch reject, centre sampling.
// byte_valid is a 1-cycle pulse after the stop bit centre; no backpressure, bytes must be taken that cycle.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err_pulse
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic            rx_meta, rx_sync;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_sync) state_d = RX_START;
      end
      RX_START: begin
        // Line must still be low at mid start bit, otherwise it was a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          valid_d = rx_sync;
          ferr_d  = !rx_sync;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_data       = shift_q;
  assign byte_valid      = valid_q;
  assign frame_err_pulse = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: byte pairs -> 256x16 program memory, debounced LOAD/RUN toggle, 1-cycle registered fetch port.
// Optional LOADER_TIMEOUT_EN drops a stale half word; no backpressure, bytes arriving in RUN are dropped.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int TIMEOUT_CYC  = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  input  logic              n_but,
  input  logic [7:0]        addr_pc,
  output logic [WORD_W-1:0] data_out,
  output logic              mode,
  output logic              frame_err,
  output logic [7:0]        wr_addr
);

  if (CLKS_PER_BIT < 4 || DEBOUNCE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("uart_prog_loader: parameter out of range");
  end

  logic [7:0] rx_byte;
  logic       byte_valid, frame_err_pulse;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk             (clk),
    .reset_n         (reset_n),
    .rx              (rx),
    .byte_data       (rx_byte),
    .byte_valid      (byte_valid),
    .frame_err_pulse (frame_err_pulse)
  );

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

  logic          but_meta, but_sync, db_level, press;
  logic [DW-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      but_meta <= 1'b1;
      but_sync <= 1'b1;
      db_level <= 1'b1;
      db_cnt   <= '0;
    end else begin
      but_meta <= n_but;
      but_sync <= but_meta;
      if (but_sync == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= but_sync;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Debounced level about to fall from released to pressed.
  assign press = db_level && (but_sync != db_level) && (db_cnt == DB_LAST);

  logic       phase_lo, mem_we, to_expire;
  logic [7:0] hi_reg;
  word_t      wr_word;

  assign mem_we  = byte_valid && (mode == MODE_LOAD) && phase_lo;
  assign wr_word = '{opcode: hi_reg, operand: rx_byte};

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || !phase_lo || byte_valid || mode == MODE_RUN) to_cnt <= '0;
    else                                                         to_cnt <= to_cnt + 1'b1;
  end

  assign to_expire = phase_lo && (mode == MODE_LOAD) && !byte_valid &&
                     (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign to_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode      <= MODE_LOAD;
      wr_addr   <= '0;
      phase_lo  <= 1'b0;
      hi_reg    <= '0;
      frame_err <= 1'b0;
    end else begin
      if (byte_valid && mode == MODE_LOAD) begin
        if (phase_lo) begin
          wr_addr  <= wr_addr + 1'b1;
          phase_lo <= 1'b0;
        end else begin
          hi_reg   <= rx_byte;
          phase_lo <= 1'b1;
        end
      end else if (to_expire) begin
        phase_lo <= 1'b0;
      end
      if (frame_err_pulse) frame_err <= 1'b1;
      // Toggle decisions use the pre-toggle mode; re-entering LOAD restarts the load.
      if (press) begin
        mode <= ~mode;
        if (mode == MODE_RUN) begin
          wr_addr   <= '0;
          phase_lo  <= 1'b0;
          frame_err <= 1'b0;
        end
      end
    end
  end

  logic [WORD_W-1:0] mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) data_out <= '0;
    else          data_out <= mem[addr_pc];
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with short bit and debounce periods.
module tb_uart_prog_loader;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int TO  = 1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;
  logic        n_but = 1'b1;
  logic [7:0]  addr_pc = 8'd0;
  logic [15:0] data_out;
  logic        mode;
  logic        frame_err;
  logic [7:0]  wr_addr;

  int total = 0;
  int bad   = 0;
  int w;
  logic [7:0]  ab;
  logic [15:0] word1;

  always #5 clk = ~clk;

  uart_prog_loader #(
    .CLKS_PER_BIT (CPB),
    .DEBOUNCE_CYC (DB),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .n_but     (n_but),
    .addr_pc   (addr_pc),
    .data_out  (data_out),
    .mode      (mode),
    .frame_err (frame_err),
    .wr_addr   (wr_addr)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_ok;
    tick(stop_ok ? 12 : CPB);
    rx = 1'b1;
    if (!stop_ok) tick(CPB);
  endtask

  task automatic rd(input logic [7:0] a);
    addr_pc = a;
    tick(2);
  endtask

  initial begin
    tick(3);
    chk("rst_mode", {15'd0, mode}, 16'd0);
    chk("rst_wr_addr", {8'd0, wr_addr}, 16'd0);
    chk("rst_data_out", data_out, 16'h0000);
    chk("rst_frame_err", {15'd0, frame_err}, 16'd0);
    reset_n = 1'b1;
    tick(2);

    // Two words from reset
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    tick(4);
    chk("load2_wr_addr", {8'd0, wr_addr}, 16'd2);
    rd(8'd0);
    chk("load2_mem0", data_out, 16'h1234);
    addr_pc = 8'd1;
    #1;
    chk("read_latency_old", data_out, 16'h1234);
    tick(1);
    chk("read_latency_new", data_out, 16'hABCD);

    // Short low glitch on rx
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    chk("glitch_frame_err", {15'd0, frame_err}, 16'd0);
    chk("glitch_wr_addr", {8'd0, wr_addr}, 16'd2);

    // Bad stop bit, then a good pair
    send_byte(8'h55, 1'b0);
    send_byte(8'h9A, 1'b1);
    send_byte(8'hBC, 1'b1);
    tick(4);
    chk("ferr_flag", {15'd0, frame_err}, 16'd1);
    chk("ferr_wr_addr", {8'd0, wr_addr}, 16'd3);
    rd(8'd2);
    chk("ferr_mem2", data_out, 16'h9ABC);

    // Bouncy press toggles to RUN once
    for (int i = 0; i < 5; i++) begin
      n_but = i[0];
      tick(1);
    end
    n_but = 1'b0;
    tick(4);
    chk("bounce_not_yet", {15'd0, mode}, 16'd0);
    tick(12);
    chk("press_run", {15'd0, mode}, 16'd1);
    tick(20);
    chk("hold_run", {15'd0, mode}, 16'd1);
    n_but = 1'b1;
    tick(20);
    chk("release_run", {15'd0, mode}, 16'd1);

    // Bytes in RUN are dropped
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    tick(4);
    chk("run_wr_addr", {8'd0, wr_addr}, 16'd3);
    rd(8'd2);
    chk("run_mem2", data_out, 16'h9ABC);

    // Back to LOAD restarts the load
    n_but = 1'b0;
    tick(14);
    n_but = 1'b1;
    tick(14);
    chk("reload_mode", {15'd0, mode}, 16'd0);
    chk("reload_wr_addr", {8'd0, wr_addr}, 16'd0);
    chk("reload_frame_err", {15'd0, frame_err}, 16'd0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(4);
    chk("reload_wr_addr1", {8'd0, wr_addr}, 16'd1);
    rd(8'd0);
    chk("reload_mem0", data_out, 16'h1122);

    // Long gap after a high byte
    send_byte(8'h12, 1'b1);
    tick(TO + 50);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    tick(4);
    chk("gap_wr_addr", {8'd0, wr_addr}, 16'd2);
    rd(8'd1);
`ifdef LOADER_TIMEOUT_EN
    word1 = 16'h3456;
    chk("gap_mem1", data_out, word1);
    w = 2;
`else
    word1 = 16'h1234;
    chk("gap_mem1", data_out, word1);
    send_byte(8'h78, 1'b1);
    tick(4);
    chk("gap_wr_addr3", {8'd0, wr_addr}, 16'd3);
    rd(8'd2);
    chk("gap_mem2", data_out, 16'h5678);
    w = 3;
`endif

    // Fill to the top of memory, then wrap
    for (int a = w; a < 256; a++) begin
      ab = a[7:0];
      send_byte(8'h5A ^ ab, 1'b1);
      send_byte(ab, 1'b1);
    end
    tick(4);
    chk("fill_wr_addr_wrap", {8'd0, wr_addr}, 16'd0);
    rd(8'd255);
    chk("fill_mem255", data_out, 16'hA5FF);
    ab = w[7:0];
    rd(ab);
    chk("fill_mem_first", data_out, {8'h5A ^ ab, ab});
    send_byte(8'hEE, 1'b1);
    send_byte(8'hFF, 1'b1);
    tick(4);
    chk("wrap_wr_addr", {8'd0, wr_addr}, 16'd1);
    rd(8'd0);
    chk("wrap_mem0", data_out, 16'hEEFF);
    rd(8'd1);
    chk("wrap_mem1_kept", data_out, word1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
